// File: rtl/touch_pkg.sv
// touch_pkg: definitions shared by the touch press filter and its helpers.
//   COORD_W   - width of raw X/Y/Z and of the averaged coordinates
//   Z_MIN_DEF - default pressure threshold (inclusive)
//   touch_state_t - press/release FSM state encoding
//   is_touched()  - pressure qualification of one sample
package touch_pkg;

   localparam int COORD_W = 12;

   typedef logic [COORD_W-1:0] coord_t;

   localparam coord_t Z_MIN_DEF = 12'd100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      ACCUM = 2'd2,
      HELD  = 2'd3
   } touch_state_t;

   // A sample counts as a touch when the pressure reaches the threshold.
   function automatic logic is_touched(input coord_t z, input coord_t z_min);
      return (z >= z_min);
   endfunction

endpackage

// File: rtl/touch_press_filter_if.sv
// touch_press_filter_if: groups the raw touch inputs and the filtered event
// outputs of touch_press_filter.
//   X, Y, Z        - raw coordinates and pressure (free running)
//   press_valid    - one-cycle press event, press_x/press_y valid from here
//   press_x/y      - averaged coordinate of the last accepted press
//   touching       - level, high between press and release
//   release_valid  - one-cycle release event
//   move_valid     - one-cycle drag update (0 unless drag support is built)
// Modports:
//   master - the filter: consumes X/Y/Z, drives the events
//   slave  - the touch source / menu side
interface touch_press_filter_if;
   import touch_pkg::*;

   coord_t X;
   coord_t Y;
   coord_t Z;
   logic   press_valid;
   coord_t press_x;
   coord_t press_y;
   logic   touching;
   logic   release_valid;
   logic   move_valid;

   modport master (
      input  X, Y, Z,
      output press_valid, press_x, press_y, touching, release_valid, move_valid
   );

   modport slave (
      output X, Y, Z,
      input  press_valid, press_x, press_y, touching, release_valid, move_valid
   );

endinterface

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running divider producing a one-cycle tick every
// SAMPLE_DIV clocks. The counter runs 0..SAMPLE_DIV-1 and tick is high while
// it sits at the top value, so the first tick lands SAMPLE_DIV cycles after
// reset is released. SAMPLE_DIV=1 gives a tick every cycle.
//   CLK_I - clock
//   reset - synchronous, active-high
//   tick  - one-cycle strobe at the counter wrap
module sample_tick_gen #(
   parameter int SAMPLE_DIV = 1000
) (
   input  logic CLK_I,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(SAMPLE_DIV - 1));

   always_ff @(posedge CLK_I) begin
      if (reset)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/touch_press_filter.sv
// touch_press_filter: turns raw touchscreen X/Y/Z into clean press/release
// events for the menu controller.
//   CLK_I  - clock
//   reset  - synchronous, active-high; clears all state and outputs
//   bus    - touch_press_filter_if.master (raw inputs, event outputs)
// Operation: X/Y/Z are captured on every sample tick. In the cycle after the
// tick the FSM judges that registered sample: DEB_SAMPLES touched samples arm
// a press, the next 2^AVG_LOG2 touched samples are averaged, and the press
// event fires with the average. DEB_SAMPLES consecutive untouched samples in
// HELD produce the release event. Any untouched sample before the press
// completes drops back to IDLE.
// Event outputs are decoded from the registered sample in the cycle after the
// tick, so press_valid/release_valid/move_valid are single-cycle by
// construction (the registered sample is only valid for that one cycle).
// Optional build macro: TOUCH_DRAG_EN - while HELD, keep averaging touched
// samples and publish each new window on press_x/press_y with move_valid.
module touch_press_filter
   import touch_pkg::*;
#(
   parameter int     SAMPLE_DIV  = 1000,
   parameter int     DEB_SAMPLES = 3,
   parameter int     AVG_LOG2    = 2,
   parameter coord_t Z_MIN       = Z_MIN_DEF
) (
   input logic                  CLK_I,
   input logic                  reset,
   touch_press_filter_if.master bus
);

   localparam int NSAMP = 1 << AVG_LOG2;
   localparam int SUM_W = COORD_W + AVG_LOG2;
   localparam int N_W   = AVG_LOG2 + 1;
   localparam int DEB_W = $clog2(DEB_SAMPLES + 1);

   typedef logic [SUM_W-1:0] sum_t;

   // ---------------------------------------------------------------- tick
   logic tick;

   sample_tick_gen #(
      .SAMPLE_DIV(SAMPLE_DIV)
   ) u_tick (
      .CLK_I (CLK_I),
      .reset (reset),
      .tick  (tick)
   );

   // ------------------------------------------------------ sample capture
   coord_t smp_x;
   coord_t smp_y;
   logic   smp_touch;
   logic   smp_vld;   // registered sample is fresh this cycle

   always_ff @(posedge CLK_I) begin
      if (reset) begin
         smp_x     <= '0;
         smp_y     <= '0;
         smp_touch <= 1'b0;
         smp_vld   <= 1'b0;
      end else begin
         smp_vld <= tick;
         if (tick) begin
            smp_x     <= bus.X;
            smp_y     <= bus.Y;
            smp_touch <= is_touched(bus.Z, Z_MIN);
         end
      end
   end

   // ------------------------------------------------------------- state
   touch_state_t     state, state_d;
   logic [DEB_W-1:0] deb_cnt, deb_d;
   logic [DEB_W-1:0] rel_cnt, rel_d;
   logic [N_W-1:0]   n, n_d;
   sum_t             sx, sx_d;
   sum_t             sy, sy_d;
   coord_t           px, px_d;
   coord_t           py, py_d;

   always_ff @(posedge CLK_I) begin
      if (reset) begin
         state   <= IDLE;
         deb_cnt <= '0;
         rel_cnt <= '0;
         n       <= '0;
         sx      <= '0;
         sy      <= '0;
         px      <= '0;
         py      <= '0;
      end else begin
         state   <= state_d;
         deb_cnt <= deb_d;
         rel_cnt <= rel_d;
         n       <= n_d;
         sx      <= sx_d;
         sy      <= sy_d;
         px      <= px_d;
         py      <= py_d;
      end
   end

   // -------------------------------------------------- next state / events
   logic             press_evt;
   logic             release_evt;
`ifdef TOUCH_DRAG_EN
   logic             move_evt;
`endif
   logic [DEB_W-1:0] deb_inc;
   sum_t             sx_acc;
   sum_t             sy_acc;

   always_comb begin
      state_d     = state;
      deb_d       = deb_cnt;
      rel_d       = rel_cnt;
      n_d         = n;
      sx_d        = sx;
      sy_d        = sy;
      px_d        = px;
      py_d        = py;
      press_evt   = 1'b0;
      release_evt = 1'b0;
`ifdef TOUCH_DRAG_EN
      move_evt    = 1'b0;
`endif
      deb_inc     = '0;
      sx_acc      = sx + sum_t'(smp_x);
      sy_acc      = sy + sum_t'(smp_y);

      if (smp_vld) begin
         unique case (state)
            // IDLE and ARM share the debounce count; a first touched sample
            // counts as 1 so DEB_SAMPLES=1 goes straight to ACCUM.
            IDLE, ARM: begin
               if (smp_touch) begin
                  deb_inc = (state == IDLE) ? DEB_W'(1) : deb_cnt + DEB_W'(1);
                  if (deb_inc >= DEB_W'(DEB_SAMPLES)) begin
                     state_d = ACCUM;
                     deb_d   = '0;
                     n_d     = '0;
                     sx_d    = '0;
                     sy_d    = '0;
                  end else begin
                     state_d = ARM;
                     deb_d   = deb_inc;
                  end
               end else begin
                  state_d = IDLE;
                  deb_d   = '0;
               end
            end

            ACCUM: begin
               if (smp_touch) begin
                  sx_d = sx_acc;
                  sy_d = sy_acc;
                  n_d  = n + N_W'(1);
                  if (n == N_W'(NSAMP - 1)) begin
                     // Window complete: publish the truncated average and
                     // start HELD with empty sums.
                     press_evt = 1'b1;
                     px_d      = sx_acc[SUM_W-1:AVG_LOG2];
                     py_d      = sy_acc[SUM_W-1:AVG_LOG2];
                     state_d   = HELD;
                     rel_d     = '0;
                     n_d       = '0;
                     sx_d      = '0;
                     sy_d      = '0;
                  end
               end else begin
                  // Abort: coordinates of the previous press stay put.
                  state_d = IDLE;
                  n_d     = '0;
                  sx_d    = '0;
                  sy_d    = '0;
               end
            end

            HELD: begin
               if (!smp_touch) begin
                  if (rel_cnt == DEB_W'(DEB_SAMPLES - 1)) begin
                     release_evt = 1'b1;
                     state_d     = IDLE;
                     rel_d       = '0;
                     n_d         = '0;
                     sx_d        = '0;
                     sy_d        = '0;
                  end else begin
                     rel_d = rel_cnt + DEB_W'(1);
                  end
               end else begin
                  rel_d = '0;
`ifdef TOUCH_DRAG_EN
                  // Drag: untouched samples leave the partial window alone,
                  // touched ones extend it. Release happens only on an
                  // untouched sample, so it can never coincide with a move.
                  sx_d = sx_acc;
                  sy_d = sy_acc;
                  n_d  = n + N_W'(1);
                  if (n == N_W'(NSAMP - 1)) begin
                     move_evt = 1'b1;
                     px_d     = sx_acc[SUM_W-1:AVG_LOG2];
                     py_d     = sy_acc[SUM_W-1:AVG_LOG2];
                     n_d      = '0;
                     sx_d     = '0;
                     sy_d     = '0;
                  end
`endif
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------- outputs
   // Events are decoded from the current sample, so the new coordinate is
   // presented through px_d in the same cycle as its event. Reset forces
   // every output low even in the cycle it is first asserted.
   assign bus.press_valid   = press_evt & ~reset;
   assign bus.release_valid = release_evt & ~reset;
   assign bus.touching      = ~reset & (((state == HELD) & ~release_evt) | press_evt);
   assign bus.press_x       = reset ? '0 : px_d;
   assign bus.press_y       = reset ? '0 : py_d;
`ifdef TOUCH_DRAG_EN
   assign bus.move_valid    = move_evt & ~reset;
`else
   assign bus.move_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_touch_press_filter.sv
// tb_touch_press_filter: self-checking bench for touch_press_filter with
// SAMPLE_DIV=4, DEB_SAMPLES=3, AVG_LOG2=2, Z_MIN=100 (default build).
// The reference model works per sample tick on run lengths: a press is the
// 7th consecutive touched tick since the last idle point and reports the mean
// of the last four touched coordinates; a release is the 3rd consecutive
// untouched tick while held. Events are expected in the cycle after the tick.
module tb_touch_press_filter;
   import touch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   touch_press_filter_if bus();

   touch_press_filter #(
      .SAMPLE_DIV (4),
      .DEB_SAMPLES(3),
      .AVG_LOG2   (2),
      .Z_MIN      (12'd100)
   ) dut (
      .CLK_I (clk),
      .reset (rst),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- model
   int          cyc, run, msx, msy;
   bit          held, chk_en;
   int          xq[$];
   int          yq[$];
   logic        exp_pv, exp_rv;
   logic [11:0] exp_px, exp_py;

   always @(posedge clk) begin
      exp_pv = 1'b0;
      exp_rv = 1'b0;
      if (rst) begin
         cyc = 0; run = 0; held = 1'b0;
         xq.delete(); yq.delete();
         exp_px = '0; exp_py = '0;
      end else begin
         if (cyc % 4 == 3) begin
            if (!held) begin
               if (int'(bus.Z) >= 100) begin
                  run++;
                  xq.push_back(int'(bus.X));
                  yq.push_back(int'(bus.Y));
                  if (xq.size() > 4) begin
                     void'(xq.pop_front());
                     void'(yq.pop_front());
                  end
                  if (run == 7) begin
                     msx = 0; msy = 0;
                     foreach (xq[i]) begin msx += xq[i]; msy += yq[i]; end
                     exp_px = 12'(msx / 4);
                     exp_py = 12'(msy / 4);
                     exp_pv = 1'b1;
                     held   = 1'b1;
                     run    = 0;
                  end
               end else begin
                  run = 0;
               end
            end else begin
               if (int'(bus.Z) < 100) begin
                  run++;
                  if (run == 3) begin
                     exp_rv = 1'b1;
                     held   = 1'b0;
                     run    = 0;
                  end
               end else begin
                  run = 0;
               end
            end
         end
         cyc++;
      end
   end

   // ----------------------------------------------- per-cycle compare
   always @(negedge clk) begin
      if (chk_en) begin
         check("press_valid",   bus.press_valid,   exp_pv);
         check("release_valid", bus.release_valid, exp_rv);
         check("touching",      bus.touching,      held);
         check("press_x",       bus.press_x,       exp_px);
         check("press_y",       bus.press_y,       exp_py);
         check("move_valid",    bus.move_valid,    1'b0);
      end
   end

   // pulse counters for the directed scenarios
   int n_press = 0;
   int n_rel   = 0;
   always @(negedge clk) begin
      if (bus.press_valid === 1'b1)   n_press++;
      if (bus.release_valid === 1'b1) n_rel++;
   end

   // ---------------------------------------------------------- stimulus
   // Each call spans exactly one sample period, aligned to the tick grid.
   task automatic run_ticks(input int n, input int x, input int y, input int z);
      for (int i = 0; i < n; i++) begin
         bus.X = 12'(x);
         bus.Y = 12'(y);
         bus.Z = 12'(z);
         repeat (4) @(negedge clk);
         #1;
      end
   endtask

   // Check a pulse has dropped, then finish the current period unchanged.
   task automatic pulse_gone(input string name);
      @(negedge clk); #1;
      check(name, {30'd0, bus.press_valid, bus.release_valid}, 32'd0);
      repeat (3) @(negedge clk);
      #1;
   endtask

   int base_p, base_r, zr;
   bit hi_bias;

   initial begin
      bus.X = 12'd1000; bus.Y = 12'd2000; bus.Z = 12'd500;

      // Reset: 3 cycles with Z=500 driven
      rst = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_press_valid", bus.press_valid, 0);
      check("rst_touching",    bus.touching,    0);
      check("rst_release",     bus.release_valid, 0);
      check("rst_press_x",     bus.press_x,     0);
      check("rst_press_y",     bus.press_y,     0);
      rst = 1'b0;

      // Clean press
      run_ticks(6, 1000, 2000, 500);
      check("no_press_before_7th", n_press, 0);
      run_ticks(1, 1000, 2000, 500);
      check("clean_press_valid", bus.press_valid, 1);
      check("clean_press_x",     bus.press_x,     1000);
      check("clean_press_y",     bus.press_y,     2000);
      check("clean_touching",    bus.touching,    1);
      check("model_clean_x",     exp_px,          1000);
      pulse_gone("clean_single_pulse");
      check("clean_press_count", n_press, 1);

      // Release debounce with a bounce
      run_ticks(2, 0, 0, 0);
      run_ticks(1, 1000, 2000, 500);
      run_ticks(2, 0, 0, 0);
      check("no_early_release", n_rel, 0);
      run_ticks(1, 0, 0, 0);
      check("release_valid",    bus.release_valid, 1);
      check("release_touching", bus.touching,      0);
      check("release_no_press", bus.press_valid,   0);
      pulse_gone("release_single_pulse");

      // Averaging
      run_ticks(3, 7, 7, 500);
      for (int i = 0; i < 4; i++) run_ticks(1, 1000 + i, 4095, 500);
      check("avg_press_valid", bus.press_valid, 1);
      check("avg_press_x",     bus.press_x,     1001);
      check("avg_press_y",     bus.press_y,     4095);
      check("model_avg_x",     exp_px,          1001);
      run_ticks(3, 0, 0, 0);
      check("avg_release", bus.release_valid, 1);

      // Bounce below threshold, then exactly at threshold
      base_p = n_press;
      run_ticks(2, 5, 5, 500);
      run_ticks(3, 5, 5, 99);
      check("bounce_no_press", n_press - base_p, 0);
      check("bounce_touching", bus.touching, 0);
      check("bounce_x_kept",   bus.press_x, 1001);
      run_ticks(7, 300, 400, 100);
      check("zmin_press_valid", bus.press_valid, 1);
      check("zmin_press_x",     bus.press_x,     300);
      check("zmin_press_y",     bus.press_y,     400);
      run_ticks(3, 0, 0, 0);

      // Reset mid-ACCUM, then a full re-press
      base_p = n_press;
      run_ticks(5, 800, 900, 500);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("midrst_touching", bus.touching,    0);
      check("midrst_press",    bus.press_valid, 0);
      check("midrst_press_x",  bus.press_x,     0);
      rst = 1'b0;
      run_ticks(6, 800, 900, 500);
      check("midrst_no_press", n_press - base_p, 0);
      run_ticks(1, 800, 900, 500);
      check("repress_valid", bus.press_valid, 1);
      check("repress_x",     bus.press_x,     800);
      run_ticks(3, 0, 0, 0);

      // Randomized: alternate touch-heavy and release-heavy stretches
      base_p = n_press;
      base_r = n_rel;
      for (int blk = 0; blk < 16; blk++) begin
         hi_bias = ~blk[0];
         for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 99) < (hi_bias ? 90 : 30))
               zr = int'($urandom_range(100, 4095));
            else
               zr = int'($urandom_range(0, 99));
            run_ticks(1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), zr);
         end
      end
      check("random_saw_press",   int'(n_press - base_p > 0), 1);
      check("random_saw_release", int'(n_rel - base_r > 0),   1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/touch_press_filter.md
Name: touch_press_filter

Overview:
- Sits between the touchscreen controller's raw X/Y/Z outputs and the menu controller.
- Samples the free-running 12-bit coordinates at a fixed rate, qualifies them by pressure, and debounces press and release.
- Averages a window of samples and emits one clean press event with a stable coordinate, plus a release event.
- The menu controller consumes the single-cycle events instead of raw, noisy levels.

Parameters:
- SAMPLE_DIV, 1000: clock cycles between sample ticks; 1 means a tick every cycle.
- DEB_SAMPLES, 3: consecutive qualifying ticks required to accept a press, and to accept a release.
- AVG_LOG2, 2: log2 of the number of samples averaged per coordinate.
- Z_MIN, 12'd100: pressure threshold. A sample is "touched" when Z >= Z_MIN (inclusive).

Ports:
- CLK_I  in  1  system clock
- reset  in  1  synchronous, active-high reset
- X  in  12  raw touch X from the touchscreen controller
- Y  in  12  raw touch Y
- Z  in  12  raw touch pressure
- press_valid  out  1  one-cycle pulse; press_x/press_y are valid from this cycle
- press_x  out  12  averaged X of the last accepted press, held until the next press
- press_y  out  12  averaged Y, same holding rule as press_x
- touching  out  1  level, high from press_valid until release_valid
- release_valid  out  1  one-cycle pulse when a debounced release is accepted
- move_valid  out  1  drag update pulse; see Optional Feature

Behaviour:
- Reset and clocking:
  - Single clock CLK_I; reset is synchronous and active-high.
  - Reset clears every output to 0, state to IDLE, and all counters and sums to 0. This holds in every state, including mid-operation.
- Sample tick:
  - The tick counter counts 0..SAMPLE_DIV-1 and asserts tick for one cycle at the wrap.
  - X/Y/Z are registered on the tick cycle; all decisions use the registered sample.
  - The first tick occurs SAMPLE_DIV cycles after reset is released.
- IDLE:
  - touched tick -> ARM with deb_cnt=1.
- ARM:
  - touched tick: deb_cnt++. When deb_cnt reaches DEB_SAMPLES -> ACCUM, with sums and sample count n cleared.
  - untouched tick -> IDLE; no output.
- ACCUM:
  - touched tick: sx+=X, sy+=Y, n++.
  - When n reaches 2^AVG_LOG2:
    - press_x = sx>>AVG_LOG2 and press_y = sy>>AVG_LOG2 (truncating).
    - press_valid=1 for exactly the next cycle; touching=1.
    - -> HELD.
  - untouched tick -> IDLE (abort); no press_valid, and press_x/press_y are unchanged.
- HELD:
  - untouched tick: rel_cnt++.
  - touched tick: rel_cnt=0.
  - When rel_cnt reaches DEB_SAMPLES: release_valid=1 for one cycle, touching=0 in the same cycle, -> IDLE.
- Arithmetic:
  - Sums are 12+AVG_LOG2 bits wide and unsigned; no overflow is possible.
  - Comparisons are unsigned.
- Exclusivity:
  - press_valid and release_valid are never high in the same cycle.
  - Minimum latency from the first touched tick to press_valid is (DEB_SAMPLES+2^AVG_LOG2) ticks plus 1 cycle.
- Non-tick cycles: state, counters and sums are held.

Optional Feature:
- Macro TOUCH_DRAG_EN.
- When defined:
  - HELD also accumulates touched ticks into the sums.
  - Every 2^AVG_LOG2 touched ticks, press_x/press_y update and move_valid pulses for one cycle.
  - Untouched ticks do not accumulate but do not clear the partial sum; the partial sum is cleared on entry to HELD and on release.
  - move_valid never coincides with press_valid or release_valid; release takes priority and discards the partial sum.
- When undefined: move_valid is tied to 0, and press_x/press_y change only on press_valid.

Decomposition:
- Shared package touch_pkg contains:
  - the state encoding (IDLE, ARM, ACCUM, HELD);
  - the 12-bit coordinate width constant;
  - the default Z_MIN.
- One sub-module, sample_tick_gen (parameter SAMPLE_DIV; ports CLK_I, reset, tick), which menu logic can also reuse.

Test Plan:
All scenarios use SAMPLE_DIV=4, DEB_SAMPLES=3, AVG_LOG2=2, Z_MIN=100.
- Reset: assert reset for 3 cycles with Z=500 -> all outputs 0; after release, no press_valid before the 7th tick.
- Clean press: X=1000, Y=2000, Z=500 held constant -> press_valid is a single pulse in the cycle after the 7th tick, with press_x=1000, press_y=2000, touching=1.
- Averaging: during the ACCUM ticks, X=1000,1001,1002,1003 and Y=4095 x4 -> press_x=1001 (4006>>2), press_y=4095.
- Bounce and threshold: Z=500 for 2 ticks, then Z=99 -> back to IDLE, no pulse. Z=100 exactly for all ticks -> press accepted.
- Release debounce: after a press, Z=0 for 2 ticks, then Z=500, then Z=0 for 3 ticks -> a single release_valid after the 3rd consecutive low tick, touching=0 in that cycle, and no earlier pulse.
- Reset mid-ACCUM: reset after the 5th tick -> no press_valid, touching=0. A re-press then needs the full 7 ticks.
